// File: rtl/core_frontend_ctrl_pkg.sv
// Shared pipeline types for the frontend controller: frontend response, cacheop and idle FSM
// states, and the redirect-priority encoding.
package core_frontend_ctrl_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } frontend_resp_t;

    typedef enum logic [1:0] {CopIdle, CopSend, CopSkip, CopWait} cop_state_e;

    typedef enum logic {IdleRun, IdleSleep} idle_state_e;

    typedef enum logic [1:0] {RedirNone, RedirBr, RedirIdle, RedirExcp} redir_src_e;

    // Exception beats idle beats branch; the losers are simply dropped.
    function automatic redir_src_e redir_sel(input logic excp, input logic idle, input logic br);
        if (excp) return RedirExcp;
        if (idle) return RedirIdle;
        if (br)   return RedirBr;
        return RedirNone;
    endfunction

endpackage

// File: rtl/core_frontend_ctrl_if.sv
// Cacheop bus between the backend request port, the sequencer and the frontend icache side.
interface core_frontend_ctrl_if;
    logic        cop_valid;
    logic [1:0]  cop;
    logic [31:0] cop_addr;
    logic        cop_ready;
    logic        cop_done;
    logic        icache_op_valid;
    logic [1:0]  icache_op;
    logic [31:0] icache_op_addr;
    logic        icache_ready;

    modport master (
        output cop_valid, cop, cop_addr, icache_ready,
        input  cop_ready, cop_done, icache_op_valid, icache_op, icache_op_addr
    );

    modport slave (
        input  cop_valid, cop, cop_addr, icache_ready,
        output cop_ready, cop_done, icache_op_valid, icache_op, icache_op_addr
    );
endinterface

// File: rtl/core_icacheop_seq.sv
// Cacheop sequencer: accept a request, present it to the icache for one cycle, skip the latch
// edge, then wait for icache_ready and pulse done.
module core_icacheop_seq
    import core_frontend_ctrl_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    core_frontend_ctrl_if.slave bus
);

    cop_state_e  st_q, st_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic        done_q, done_d;

    always_comb begin
        st_d   = st_q;
        op_d   = op_q;
        addr_d = addr_q;
        done_d = 1'b0;
        unique case (st_q)
            CopIdle: begin
                if (bus.cop_valid) begin
                    op_d   = bus.cop;
                    addr_d = bus.cop_addr;
                    st_d   = CopSend;
                end
            end
            CopSend: st_d = CopSkip;
            // icache_ready may still reflect the previous op while the frontend latches this one
            CopSkip: st_d = CopWait;
            CopWait: begin
                if (bus.icache_ready) begin
                    done_d = 1'b1;
                    st_d   = CopIdle;
                end
            end
            default: st_d = CopIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= CopIdle;
            op_q   <= '0;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            op_q   <= op_d;
            addr_q <= addr_d;
            done_q <= done_d;
        end
    end

    assign bus.cop_ready       = (st_q == CopIdle) & ~rst;
    assign bus.cop_done        = done_q;
    assign bus.icache_op_valid = (st_q == CopSend);
    assign bus.icache_op       = op_q;
    assign bus.icache_op_addr  = addr_q;

endmodule

// File: rtl/core_frontend_ctrl.sv
// Frontend controller: in-order dual issue, registered redirect arbitration, cacheop sequencing
// and, when FE_CTRL_IDLE_EN is defined, the idle/sleep FSM.
module core_frontend_ctrl
    import core_frontend_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  inst_valid_i,
    input  logic [1:0]  be_ready_i,
    output logic [1:0]  issue_o,
    input  logic        excp_redir_i,
    input  logic [31:0] excp_target_i,
    input  logic        br_redir_i,
    input  logic [31:0] br_target_i,
    output logic        rst_jmp_o,
    output logic [31:0] rst_jmp_target_o,
    input  logic        cop_valid_i,
    input  logic [1:0]  cop_i,
    input  logic [31:0] cop_addr_i,
    output logic        cop_ready_o,
    output logic        cop_done_o,
    output logic        icache_op_valid_o,
    output logic [1:0]  icache_op_o,
    output logic [31:0] icacheop_addr_o,
    input  logic        icache_ready_i,
    input  logic        idle_commit_i,
    input  logic [31:0] idle_pc_i,
    input  logic        int_pending_i,
    output logic        wait_inst_o,
    output logic        int_detect_o
);

    redir_src_e  src;
    logic        rst_jmp_q, rst_jmp_d;
    logic [31:0] target_q, target_d;
    logic        sleeping;
    logic        block_issue;

    always_comb begin
        src       = redir_sel(excp_redir_i, idle_commit_i, br_redir_i);
        rst_jmp_d = (src != RedirNone);
        unique case (src)
            RedirExcp: target_d = excp_target_i;
            RedirIdle: target_d = idle_pc_i + 32'd4;
            RedirBr:   target_d = br_target_i;
            default:   target_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_jmp_q <= 1'b0;
            target_q  <= '0;
        end else begin
            rst_jmp_q <= rst_jmp_d;
            target_q  <= target_d;
        end
    end

`ifdef FE_CTRL_IDLE_EN
    idle_state_e idle_q, idle_d;
    logic        wait_q, wait_d;
    logic        int_det_q, int_det_d;

    always_comb begin
        idle_d    = idle_q;
        wait_d    = 1'b0;
        int_det_d = 1'b0;
        unique case (idle_q)
            IdleRun: begin
                // A pending interrupt would wake us immediately, so don't bother sleeping
                if (src == RedirIdle && !int_pending_i) begin
                    wait_d = 1'b1;
                    idle_d = IdleSleep;
                end
            end
            IdleSleep: begin
                if (int_pending_i || excp_redir_i) begin
                    int_det_d = 1'b1;
                    idle_d    = IdleRun;
                end
            end
            default: idle_d = IdleRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= IdleRun;
            wait_q    <= 1'b0;
            int_det_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            wait_q    <= wait_d;
            int_det_q <= int_det_d;
        end
    end

    assign sleeping     = (idle_q == IdleSleep);
    assign wait_inst_o  = wait_q;
    assign int_detect_o = int_det_q;
`else
    logic unused_int_pending;
    assign unused_int_pending = int_pending_i;
    assign sleeping           = 1'b0;
    assign wait_inst_o        = 1'b0;
    assign int_detect_o       = 1'b0;
`endif

    assign block_issue      = rst | rst_jmp_q | sleeping;
    assign issue_o[0]       = inst_valid_i[0] & be_ready_i[0] & ~block_issue;
    assign issue_o[1]       = issue_o[0] & inst_valid_i[1] & be_ready_i[1];
    assign rst_jmp_o        = rst_jmp_q;
    assign rst_jmp_target_o = target_q;

    core_frontend_ctrl_if cop_bus ();

    assign cop_bus.cop_valid    = cop_valid_i;
    assign cop_bus.cop          = cop_i;
    assign cop_bus.cop_addr     = cop_addr_i;
    assign cop_bus.icache_ready = icache_ready_i;
    assign cop_ready_o          = cop_bus.cop_ready;
    assign cop_done_o           = cop_bus.cop_done;
    assign icache_op_valid_o    = cop_bus.icache_op_valid;
    assign icache_op_o          = cop_bus.icache_op;
    assign icacheop_addr_o      = cop_bus.icache_op_addr;

    core_icacheop_seq u_icacheop_seq (
        .clk (clk),
        .rst (rst),
        .bus (cop_bus)
    );

endmodule

// File: tb/tb_core_frontend_ctrl.sv
// Self-checking bench for core_frontend_ctrl: directed scenarios followed by random stimulus,
// all compared against a cycle-level behavioural model.
module tb_core_frontend_ctrl;

`ifdef FE_CTRL_IDLE_EN
    localparam bit IdleEn = 1'b1;
`else
    localparam bit IdleEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  inst_valid, be_ready, issue;
    logic        excp_redir, br_redir, idle_commit, int_pending;
    logic [31:0] excp_target, br_target, idle_pc;
    logic        rst_jmp, wait_inst, int_detect;
    logic [31:0] rst_jmp_target;

    core_frontend_ctrl_if cop_bus ();

    core_frontend_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .inst_valid_i      (inst_valid),
        .be_ready_i        (be_ready),
        .issue_o           (issue),
        .excp_redir_i      (excp_redir),
        .excp_target_i     (excp_target),
        .br_redir_i        (br_redir),
        .br_target_i       (br_target),
        .rst_jmp_o         (rst_jmp),
        .rst_jmp_target_o  (rst_jmp_target),
        .cop_valid_i       (cop_bus.cop_valid),
        .cop_i             (cop_bus.cop),
        .cop_addr_i        (cop_bus.cop_addr),
        .cop_ready_o       (cop_bus.cop_ready),
        .cop_done_o        (cop_bus.cop_done),
        .icache_op_valid_o (cop_bus.icache_op_valid),
        .icache_op_o       (cop_bus.icache_op),
        .icacheop_addr_o   (cop_bus.icache_op_addr),
        .icache_ready_i    (cop_bus.icache_ready),
        .idle_commit_i     (idle_commit),
        .idle_pc_i         (idle_pc),
        .int_pending_i     (int_pending),
        .wait_inst_o       (wait_inst),
        .int_detect_o      (int_detect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: cop_age counts edges since a cacheop was accepted (0 = idle).
    logic        m_rst_jmp, m_wait, m_intdet, m_asleep, m_done;
    logic [31:0] m_target, m_addr;
    logic [1:0]  m_op;
    int          cop_age;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rst_jmp = 1'b0;
        m_target  = '0;
        m_wait    = 1'b0;
        m_intdet  = 1'b0;
        m_asleep  = 1'b0;
        m_done    = 1'b0;
        m_op      = '0;
        m_addr    = '0;
        cop_age   = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
            return;
        end
        m_rst_jmp = excp_redir | idle_commit | br_redir;
        if (excp_redir)       m_target = excp_target;
        else if (idle_commit) m_target = idle_pc + 32'd4;
        else if (br_redir)    m_target = br_target;
        else                  m_target = '0;

        m_wait   = 1'b0;
        m_intdet = 1'b0;
        if (IdleEn) begin
            if (m_asleep) begin
                if (int_pending || excp_redir) begin
                    m_intdet = 1'b1;
                    m_asleep = 1'b0;
                end
            end else if (idle_commit && !excp_redir && !int_pending) begin
                m_wait   = 1'b1;
                m_asleep = 1'b1;
            end
        end

        m_done = 1'b0;
        if (cop_age == 0) begin
            if (cop_bus.cop_valid) begin
                cop_age = 1;
                m_op    = cop_bus.cop;
                m_addr  = cop_bus.cop_addr;
            end
        end else if (cop_age >= 3 && cop_bus.icache_ready) begin
            cop_age = 0;
            m_done  = 1'b1;
        end else begin
            cop_age++;
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next one.
    task automatic tick();
        logic [1:0] exp_issue;
        logic       blk;
        #1;
        blk          = rst | m_rst_jmp | m_asleep;
        exp_issue[0] = inst_valid[0] & be_ready[0] & ~blk;
        exp_issue[1] = exp_issue[0] & inst_valid[1] & be_ready[1];
        check("issue", issue, exp_issue);
        @(posedge clk);
        model_edge();
        #1;
        check("rst_jmp", rst_jmp, m_rst_jmp);
        check("rst_jmp_target", rst_jmp_target, m_target);
        check("wait_inst", wait_inst, m_wait);
        check("int_detect", int_detect, m_intdet);
        check("cop_ready", cop_bus.cop_ready, (cop_age == 0) && !rst);
        check("cop_done", cop_bus.cop_done, m_done);
        check("icache_op_valid", cop_bus.icache_op_valid, cop_age == 1);
        check("icache_op", cop_bus.icache_op, m_op);
        check("icache_op_addr", cop_bus.icache_op_addr, m_addr);
        @(negedge clk);
    endtask

    task automatic quiet();
        excp_redir           = 1'b0;
        br_redir             = 1'b0;
        idle_commit          = 1'b0;
        int_pending          = 1'b0;
        cop_bus.cop_valid    = 1'b0;
        cop_bus.icache_ready = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        inst_valid           = 2'b00;
        be_ready             = 2'b00;
        excp_target          = '0;
        br_target            = '0;
        idle_pc              = '0;
        cop_bus.cop          = '0;
        cop_bus.cop_addr     = '0;
        quiet();
        model_reset();
        @(negedge clk);

        // Reset state
        tick();
        tick();
        check("reset_rst_jmp", rst_jmp, 1'b0);
        check("reset_cop_ready", cop_bus.cop_ready, 1'b0);
        rst = 1'b0;
        tick();
        check("post_reset_cop_ready", cop_bus.cop_ready, 1'b1);

        // Dual issue and in-order gap rule
        inst_valid = 2'b11;
        be_ready   = 2'b11;
        #1 check("dual_issue_11", issue, 2'b11);
        tick();
        be_ready = 2'b10;
        #1 check("dual_issue_10", issue, 2'b00);
        tick();
        be_ready = 2'b11;

        // Exception and branch redirect in the same cycle
        excp_redir  = 1'b1;
        excp_target = 32'h1c00_0000;
        br_redir    = 1'b1;
        br_target   = 32'h1c00_0040;
        tick();
        quiet();
        check("collide_rst_jmp", rst_jmp, 1'b1);
        check("collide_target", rst_jmp_target, 32'h1c00_0000);
        #1 check("collide_issue", issue, 2'b00);
        tick();

        // Cacheop handshake
        cop_bus.cop_valid = 1'b1;
        cop_bus.cop       = 2'd2;
        cop_bus.cop_addr  = 32'h0000_1000;
        tick();
        cop_bus.cop_valid = 1'b0;
        check("cop_send_valid", cop_bus.icache_op_valid, 1'b1);
        check("cop_send_op", cop_bus.icache_op, 2'd2);
        check("cop_busy_ready", cop_bus.cop_ready, 1'b0);
        cop_bus.icache_ready = 1'b1;
        tick();
        cop_bus.icache_ready = 1'b0;
        check("cop_skip_no_done", cop_bus.cop_done, 1'b0);
        tick();
        tick();
        cop_bus.icache_ready = 1'b1;
        tick();
        cop_bus.icache_ready = 1'b0;
        check("cop_done_pulse", cop_bus.cop_done, 1'b1);
        tick();
        check("cop_done_once", cop_bus.cop_done, 1'b0);

        // Idle commit, sleep, interrupt wake
        idle_commit = 1'b1;
        idle_pc     = 32'h1c00_00fc;
        tick();
        idle_commit = 1'b0;
        check("idle_target", rst_jmp_target, 32'h1c00_0100);
        check("idle_wait", wait_inst, IdleEn);
        repeat (10) tick();
        int_pending = 1'b1;
        tick();
        int_pending = 1'b0;
        check("idle_int_detect", int_detect, IdleEn);
        #1 check("idle_resume_issue", issue, 2'b11);
        tick();

        // PC wrap, then idle commit colliding with a pending interrupt
        idle_commit = 1'b1;
        idle_pc     = 32'hffff_fffc;
        tick();
        idle_commit = 1'b0;
        check("wrap_target", rst_jmp_target, 32'h0000_0000);
        int_pending = 1'b1;
        tick();
        idle_commit = 1'b1;
        idle_pc     = 32'h1c00_0200;
        tick();
        idle_commit = 1'b0;
        int_pending = 1'b0;
        check("idle_int_redirect", rst_jmp, 1'b1);
        check("idle_int_no_wait", wait_inst, 1'b0);
        tick();

        // Reset while waiting for the icache
        cop_bus.cop_valid = 1'b1;
        cop_bus.cop       = 2'd1;
        cop_bus.cop_addr  = 32'h0000_2040;
        tick();
        cop_bus.cop_valid = 1'b0;
        repeat (3) tick();
        rst                  = 1'b1;
        cop_bus.icache_ready = 1'b1;
        tick();
        cop_bus.icache_ready = 1'b0;
        check("rst_mid_cop_done", cop_bus.cop_done, 1'b0);
        check("rst_mid_cop_valid", cop_bus.icache_op_valid, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_mid_cop_ready", cop_bus.cop_ready, 1'b1);
        check("rst_mid_cop_no_done", cop_bus.cop_done, 1'b0);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rst                  = ($urandom_range(63) == 0);
            inst_valid           = 2'($urandom_range(3));
            be_ready             = 2'($urandom_range(3));
            excp_redir           = ($urandom_range(15) == 0);
            br_redir             = ($urandom_range(7) == 0);
            idle_commit          = ($urandom_range(15) == 0);
            int_pending          = ($urandom_range(7) == 0);
            excp_target          = $urandom;
            br_target            = $urandom;
            idle_pc              = ($urandom_range(7) == 0) ? 32'hffff_fffc : $urandom;
            cop_bus.cop_valid    = ($urandom_range(3) == 0);
            cop_bus.cop          = 2'($urandom_range(3));
            cop_bus.cop_addr     = $urandom;
            cop_bus.icache_ready = ($urandom_range(2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/core_frontend_ctrl.md
CORE_FRONTEND_CTRL -- requirements
Module: core_frontend_ctrl

Interface
REQ-001 SHALL have `clk`, input, 1: sole clock, all state updates on its rising edge.
REQ-002 SHALL have `rst`, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have `inst_valid_i`, input, 2: frontend FIFO head valid per slot.
REQ-004 SHALL have `be_ready_i`, input, 2: backend slot can accept an instruction.
REQ-005 SHALL have `issue_o`, output, 2: instructions consumed this cycle; drives frontend `issue`.
REQ-006 SHALL have `excp_redir_i`, input, 1, with `excp_target_i`, input, 32: exception/ertn redirect.
REQ-007 SHALL have `br_redir_i`, input, 1, with `br_target_i`, input, 32: branch-mispredict redirect.
REQ-008 SHALL have `rst_jmp_o`, output, 1, with `rst_jmp_target_o`, output, 32: frontend flush and new PC.
REQ-009 SHALL have `cop_valid_i`, input, 1; `cop_i`, input, 2; `cop_addr_i`, input, 32; `cop_ready_o`, output, 1: backend cacheop request port.
REQ-010 SHALL have `cop_done_o`, output, 1: one-cycle pulse when the cacheop completes.
REQ-011 SHALL have `icache_op_valid_o`, output, 1; `icache_op_o`, output, 2; `icacheop_addr_o`, output, 32; `icache_ready_i`, input, 1: frontend cacheop side.
REQ-012 SHALL have `idle_commit_i`, input, 1, with `idle_pc_i`, input, 32: idle instruction committed.
REQ-013 SHALL have `int_pending_i`, input, 1: interrupt pending.
REQ-014 SHALL have `wait_inst_o`, output, 1, and `int_detect_o`, output, 1: frontend idle control.

Function
REQ-015 SHALL compute `issue_o[0]` = `inst_valid_i[0]` & `be_ready_i[0]`, and `issue_o[1]` = `issue_o[0]` & `inst_valid_i[1]` & `be_ready_i[1]`, so issue is in order with no gaps.
REQ-016 SHALL force `issue_o` to 0 in any cycle where `rst_jmp_o` = 1 or the controller is in SLEEP.
REQ-017 SHALL register redirects: `rst_jmp_o` pulses exactly one cycle after the request cycle, with the target registered alongside it.
REQ-018 SHALL give priority on simultaneous redirect requests: exception > idle > branch; a lower-priority request in the same cycle is dropped.
REQ-019 SHALL run the cacheop sequencer through states CIDLE -> CSEND -> CSKIP -> CWAIT -> CIDLE.
REQ-020 In CIDLE, `cop_ready_o` SHALL be 1; `cop_valid_i` = 1 captures op and address and moves to CSEND.
REQ-021 CSEND SHALL drive `icache_op_valid_o` = 1 for exactly one cycle with the captured op and address.
REQ-022 CSKIP SHALL ignore `icache_ready_i` for one cycle, because the frontend latches the op on that edge.
REQ-023 CWAIT SHALL hold until `icache_ready_i` = 1, then pulse `cop_done_o` and return to CIDLE.
REQ-024 `cop_ready_o` SHALL be 0 outside CIDLE.
REQ-025 Redirects SHALL NOT abort the cacheop sequencer.
REQ-026 SHALL run the idle FSM through states RUN -> SLEEP -> RUN.
REQ-027 In RUN, `idle_commit_i` SHALL cause a one-cycle `wait_inst_o` pulse and a redirect to `idle_pc_i` + 4 (32-bit wrap), then a move to SLEEP.
REQ-028 If `int_pending_i` = 1 in the same cycle as `idle_commit_i`, the block SHALL still redirect but SHALL suppress `wait_inst_o` and stay in RUN.
REQ-029 In SLEEP, `int_pending_i` = 1 SHALL pulse `int_detect_o` for one cycle and return to RUN.
REQ-030 In SLEEP, an exception redirect SHALL also return the FSM to RUN, with `int_detect_o` pulsed.

Reset
REQ-031 On `rst` = 1, all outputs SHALL be 0, the cacheop FSM SHALL be in CIDLE, and the idle FSM in RUN.
REQ-032 Reset during a cacheop SHALL drop the op with no `cop_done_o` pulse.

Configuration
REQ-033 With `FE_CTRL_IDLE_EN` defined, the idle FSM SHALL be built as specified.
REQ-034 Without `FE_CTRL_IDLE_EN`, `wait_inst_o` and `int_detect_o` SHALL be tied to 0, SLEEP SHALL not exist, and `idle_commit_i` SHALL only redirect to `idle_pc_i` + 4.

Structure
REQ-035 The cacheop and idle state enums and the redirect-priority encoding SHALL live in the shared pipeline package next to `frontend_resp_t`.
REQ-036 The cacheop sequencer SHALL be a separate sub-module, `core_icacheop_seq`.

Verification
REQ-037 Dual issue:
- `inst_valid_i` = 2'b11, `be_ready_i` = 2'b11 -> `issue_o` = 2'b11.
- `be_ready_i` = 2'b10 -> `issue_o` = 2'b00.
REQ-038 Redirect collision: `excp_redir_i`(0x1c000000) and `br_redir_i`(0x1c000040) in the same cycle -> next cycle `rst_jmp_o` = 1, target 0x1c000000, `issue_o` = 0.
REQ-039 Cacheop handshake: `cop_valid_i` with op 2, addr 0x00001000 -> `icache_op_valid_o` for 1 cycle; `icache_ready_i` high 3 cycles later -> `cop_done_o` pulses once; `cop_ready_o` low throughout.
REQ-040 Idle (macro on): idle commit at 0x1c0000fc -> `wait_inst_o` pulse, `rst_jmp_target_o` 0x1c000100, `issue_o` held 0; `int_pending_i` 10 cycles later -> `int_detect_o` pulse, issue resumes.
REQ-041 Wrap and collision:
- Idle at 0xfffffffc -> target 0x00000000.
- Idle commit with `int_pending_i` = 1 -> redirect, no `wait_inst_o`.
REQ-042 Reset mid-cacheop: `rst` asserted in CWAIT -> all outputs 0 next cycle, no `cop_done_o`, `cop_ready_o` = 1 after reset.
